img2col_seq_ctrl: RTL
=====================

# img2col_seq_ctrl

Sequencer that drives `img2col_addr_gen` across a whole convolution layer. It accepts one layer command and issues one generator `start` pulse per input channel, with a per-channel SRAM base address. It waits for each channel's final handshake, then repeats the channel sweep for a programmed number of passes (output-filter groups). It sits between the layer-level control FSM and the generator/systolic-array pair, and reports `busy`/`done` and launch progress.

## Interface
- `SRAM_ADDR_W`, 16, SRAM address width; matches the generator's `base_addr_i`.
- `CH_W`, 8, width of channel count/index.
- `PASS_W`, 8, width of pass count/index.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_async_n_i`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid_i`  in  1  layer command valid.
- `cmd_ready_o`  out  1  ready to accept a command; high only in IDLE.
- `cmd_base_i`  in  SRAM_ADDR_W  SRAM address of channel 0.
- `cmd_stride_i`  in  SRAM_ADDR_W  address step between consecutive channels.
- `cmd_num_ch_i`  in  CH_W  number of channels (0 is legal).
- `cmd_num_pass_i`  in  PASS_W  number of channel sweeps (0 is legal).
- `abort_i`  in  1  synchronous abort; returns to IDLE.
- `gen_start_o`  out  1  one-cycle start pulse to the generator.
- `gen_base_addr_o`  out  SRAM_ADDR_W  base address for the current channel; held stable from LAUNCH until the channel finishes.
- `gen_valid_i`  in  1  generator `valid_o`.
- `gen_last_i`  in  1  generator `last_out_o`.
- `systolic_ready_i`  in  1  same ready seen by the generator.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when the layer completes.
- `cur_ch_o`  out  CH_W  channel index being processed.
- `cur_pass_o`  out  PASS_W  pass index being processed.

## Operation
- Registers: `base_q`, `stride_q`, `nch_q`, `npass_q` are latched on command acceptance (`cmd_valid_i & cmd_ready_o`). Counters `ch_q`, `pass_q`. Address register `addr_q`.
- FSM states: IDLE, LAUNCH, WAIT, NEXT, DONE.
- **IDLE**: `cmd_ready_o=1`. On acceptance, latch the command and set `ch_q=0`, `pass_q=0`, `addr_q=cmd_base_i`.
  - If `cmd_num_ch_i==0` or `cmd_num_pass_i==0`, go to DONE.
  - Otherwise go to LAUNCH.
- **LAUNCH**: `gen_start_o=1` for exactly this cycle, with `gen_base_addr_o=addr_q`. Next state is WAIT.
- **WAIT**: hold. The channel is finished on a cycle where `gen_valid_i & gen_last_i & systolic_ready_i` is true; go to NEXT. If `gen_last_i` is high but `systolic_ready_i` is low, it does not count.
- **NEXT**, one cycle, with this priority:
  - If `ch_q != nch_q-1`: `ch_q++`, `addr_q += stride_q`, go to LAUNCH.
  - Else if `pass_q != npass_q-1`: `ch_q=0`, `pass_q++`, `addr_q=base_q`, go to LAUNCH.
  - Else go to DONE.
- **DONE**: `done_o=1` for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^SRAM_ADDR_W; overflow wraps silently.
- `abort_i` is sampled in every non-IDLE state and has priority over all transitions. The next state is IDLE, with no `done_o` and no further `gen_start_o`. The generator is not flushed by this block; the upstream FSM owns that.
- `cmd_valid_i` is ignored while busy.
- `gen_valid_i`/`gen_last_i` outside WAIT are ignored.

## Timing
- Reset values: `cmd_ready_o=1` (state IDLE); `gen_start_o=0`, `gen_base_addr_o=0`, `busy_o=0`, `done_o=0`, `cur_ch_o=0`, `cur_pass_o=0`; all internal registers 0.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Command accepted at edge N: `gen_start_o` is high during cycle N+1.
- Final handshake at edge M: NEXT during cycle M+1, then the next `gen_start_o` during cycle M+2. Per-channel overhead is therefore 2 cycles (LAUNCH + NEXT) beyond the generator's own duration.
- The last channel's handshake at edge M gives `done_o` high during cycle M+2, and `cmd_ready_o` high again from cycle M+3.
- A zero-count command accepted at edge N gives `done_o` during cycle N+1, and no start pulse is issued.
- `cur_ch_o`/`cur_pass_o` change only on the NEXT→LAUNCH edge, and on acceptance.
- Asynchronous reset mid-operation forces the reset values immediately; the next command is accepted normally.

## Test plan
- **Basic sweep**: base=0, stride=64, num_ch=3, num_pass=1, `ready=1`, stub generator asserting last 8 cycles after start. Expect 3 start pulses with base 0, 64, 128, then one `done_o`, and no fourth start.
- **Multi-pass**: base=100, stride=10, num_ch=2, num_pass=3. Expect base sequence 100,110,100,110,100,110, `cur_pass_o` stepping 0→1→2, and `done_o` once.
- **Backpressure**: hold `systolic_ready_i=0` while `gen_last_i=1` for 5 cycles. Expect no NEXT and no new start until ready rises, then the start 2 cycles after the handshake.
- **Zero counts**: num_ch=0, then num_pass=0. Expect `done_o` one cycle after acceptance, zero `gen_start_o`, and `busy_o` high for exactly one cycle.
- **Wrap**: base=16'hFFF0, stride=16'h0010, num_ch=3. Expect bases FFF0, 0000, 0010.
- **Abort/reset**: assert `abort_i` in WAIT of channel 1. Expect IDLE next cycle, no `done_o`, `cmd_ready_o=1`. Repeat using `rst_async_n_i` low mid-WAIT; all outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/img2col_seq_ctrl.sv
// Layer sequencer for img2col_addr_gen: one start pulse per channel,
// channel sweeps repeated per pass, with per-channel SRAM base address.
module img2col_seq_ctrl #(
    parameter int SRAM_ADDR_W = 16,
    parameter int CH_W        = 8,
    parameter int PASS_W      = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_async_n_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [SRAM_ADDR_W-1:0] cmd_base_i,
    input  logic [SRAM_ADDR_W-1:0] cmd_stride_i,
    input  logic [CH_W-1:0]        cmd_num_ch_i,
    input  logic [PASS_W-1:0]      cmd_num_pass_i,
    input  logic                   abort_i,
    output logic                   gen_start_o,
    output logic [SRAM_ADDR_W-1:0] gen_base_addr_o,
    input  logic                   gen_valid_i,
    input  logic                   gen_last_i,
    input  logic                   systolic_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CH_W-1:0]        cur_ch_o,
    output logic [PASS_W-1:0]      cur_pass_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SRAM_ADDR_W-1:0] base_q, stride_q, addr_q;
    logic [CH_W-1:0]        nch_q, ch_q;
    logic [PASS_W-1:0]      npass_q, pass_q;

    logic accept, zero_cmd, ch_more, pass_more, chan_end;

    assign accept    = cmd_valid_i & (state_q == S_IDLE);
    assign zero_cmd  = (cmd_num_ch_i == '0) | (cmd_num_pass_i == '0);
    assign ch_more   = ch_q != (nch_q - CH_W'(1));
    assign pass_more = pass_q != (npass_q - PASS_W'(1));
    assign chan_end  = gen_valid_i & gen_last_i & systolic_ready_i;

    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = zero_cmd ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (chan_end) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (ch_more || pass_more) begin
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort wins over every transition out of a busy state
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            base_q   <= '0;
            stride_q <= '0;
            nch_q    <= '0;
            npass_q  <= '0;
            ch_q     <= '0;
            pass_q   <= '0;
            addr_q   <= '0;
        end else if (accept) begin
            base_q   <= cmd_base_i;
            stride_q <= cmd_stride_i;
            nch_q    <= cmd_num_ch_i;
            npass_q  <= cmd_num_pass_i;
            ch_q     <= '0;
            pass_q   <= '0;
            addr_q   <= cmd_base_i;
        end else if ((state_q == S_NEXT) && !abort_i) begin
            if (ch_more) begin
                ch_q   <= ch_q + CH_W'(1);
                addr_q <= addr_q + stride_q;
            end else if (pass_more) begin
                ch_q   <= '0;
                pass_q <= pass_q + PASS_W'(1);
                addr_q <= base_q;
            end
        end
    end

    assign cmd_ready_o     = (state_q == S_IDLE);
    assign busy_o          = (state_q != S_IDLE);
    assign gen_start_o     = (state_q == S_LAUNCH);
    assign done_o          = (state_q == S_DONE);
    assign gen_base_addr_o = addr_q;
    assign cur_ch_o        = ch_q;
    assign cur_pass_o      = pass_q;

endmodule
